// File: rtl/tile_attr_fetch_if.sv
// Bundle for the tile fetcher: the burst command, the VRAM read port and
// the output tile stream. The fetcher is the master; the PPU side (memory,
// command source, background shifter) is the slave.
interface tile_attr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 6
);
    // Burst command
    logic              start;
    logic [1:0]        start_nt;
    logic [4:0]        start_x;
    logic [4:0]        start_y;
    logic [CNT_W-1:0]  count;
    logic              busy;

    // VRAM read port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    // Output tile stream (first-word fall-through FIFO head)
    logic              tile_valid;
    logic              tile_ready;
    logic [7:0]        tile_index;
    logic [1:0]        tile_pal;
    logic [1:0]        tile_nt;
    logic [4:0]        tile_x;

    modport master (
        input  start, start_nt, start_x, start_y, count,
        output busy,
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output tile_valid, tile_index, tile_pal, tile_nt, tile_x,
        input  tile_ready
    );

    modport slave (
        output start, start_nt, start_x, start_y, count,
        input  busy,
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  tile_valid, tile_index, tile_pal, tile_nt, tile_x,
        output tile_ready
    );
endinterface

// File: rtl/tile_attr_fetch.sv
// Background tile burst fetcher. Walks tiles left to right from a start
// position, reading the nametable byte and (on a cache miss) the attribute
// byte for each, then pushes {index, palette, nametable, x} into a small
// first-word fall-through FIFO. Crossing x=31 flips to the horizontally
// adjacent nametable.
module tile_attr_fetch #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    tile_attr_fetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, NT_RD, AT_RD, PUSH} state_t;

    typedef struct packed {
        logic [7:0] index;
        logic [1:0] pal;
        logic [1:0] nt;
        logic [4:0] x;
    } tile_t;

    state_t            state, state_nxt;
    logic [1:0]        nt_q;
    logic [4:0]        x_q, y_q;
    logic [CNT_W-1:0]  remain_q;
    logic [7:0]        index_q;
    logic              cache_valid;
    logic [13:0]       cache_addr;
    logic [7:0]        cache_data;

    logic [13:0]       nt_addr, at_addr;
    logic [2:0]        pal_shift;
    logic              cache_hit;
    logic              mem_req_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              push, pop, full, empty;

    tile_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fill;
    tile_t             head;

    // Nametable byte 0x2000|nt<<10|y<<5|x, attribute byte 0x23C0|nt<<10|(y>>2)<<3|(x>>2).
    assign nt_addr   = {2'b10, nt_q, y_q, x_q};
    assign at_addr   = {2'b10, nt_q, 4'b1111, y_q[4:2], x_q[4:2]};
    assign pal_shift = {y_q[1], x_q[1], 1'b0};
    assign cache_hit = cache_valid && (cache_addr == at_addr);

    assign full  = (fill == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (fill == '0);
    assign pop   = !empty && bus.tile_ready;

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and memory port decode.
    // NOTE: every output of this block gets a default first; otherwise a
    // path that skips an assignment infers a latch.
    always_comb begin
        state_nxt  = state;
        mem_req_c  = 1'b0;
        mem_addr_c = '0;
        push       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && (bus.count != '0)) state_nxt = NT_RD;
            end
            NT_RD: begin
                mem_req_c  = 1'b1;
                mem_addr_c = ADDR_W'(nt_addr);
                if (bus.mem_ack) state_nxt = cache_hit ? PUSH : AT_RD;
            end
            AT_RD: begin
                mem_req_c  = 1'b1;
                mem_addr_c = ADDR_W'(at_addr);
                if (bus.mem_ack) state_nxt = PUSH;
            end
            PUSH: begin
                // A same-cycle pop frees the slot even when the FIFO is full.
                if (!full || pop) begin
                    push      = 1'b1;
                    state_nxt = (remain_q == CNT_W'(1)) ? IDLE : NT_RD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst position, fetched bytes and the single-entry attribute cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            nt_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            remain_q    <= '0;
            index_q     <= '0;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
        end else begin
            if (state == IDLE && bus.start && (bus.count != '0)) begin
                nt_q        <= bus.start_nt;
                x_q         <= bus.start_x;
                y_q         <= bus.start_y;
                remain_q    <= bus.count;
                cache_valid <= 1'b0;
            end
            if (state == NT_RD && bus.mem_ack) index_q <= bus.mem_rdata;
            if (state == AT_RD && bus.mem_ack) begin
                cache_data  <= bus.mem_rdata;
                cache_addr  <= at_addr;
                cache_valid <= 1'b1;
            end
            if (push) begin
                remain_q <= remain_q - CNT_W'(1);
                x_q      <= x_q + 5'd1;
                if (x_q == 5'd31) nt_q[0] <= ~nt_q[0];
            end
        end
    end

    // FIFO storage.
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{index: index_q, pal: cache_data[pal_shift +: 2],
                                        nt: nt_q, x: x_q};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (PTR_W+1)'(1);
                2'b01:   fill <= fill - (PTR_W+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    assign head           = fifo_mem[rd_ptr];
    assign bus.busy       = (state != IDLE);
    assign bus.mem_req    = mem_req_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.tile_valid = !empty;
    assign bus.tile_index = empty ? 8'd0 : head.index;
    assign bus.tile_pal   = empty ? 2'd0 : head.pal;
    assign bus.tile_nt    = empty ? 2'd0 : head.nt;
    assign bus.tile_x     = empty ? 5'd0 : head.x;
endmodule

// File: tb/tb_tile_attr_fetch.sv
// Self-checking bench for tile_attr_fetch. Stimulus pushes hand-computed
// expected VRAM reads and output tiles into queues; the memory responder
// and the tile monitor pop and compare as the DUT produces them.
module tb_tile_attr_fetch;
    typedef struct packed {
        logic [7:0] index;
        logic [1:0] pal;
        logic [1:0] nt;
        logic [4:0] x;
    } exp_tile_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_attr_fetch_if #(.ADDR_W(16), .CNT_W(6)) bus ();

    tile_attr_fetch #(.ADDR_W(16), .FIFO_DEPTH(4), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  vram [0:16383];
    logic [15:0] addr_q [$];
    exp_tile_t   tile_q [$];
    int          min_delay = 0;
    int          max_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic exp_read(input logic [15:0] a);
        addr_q.push_back(a);
    endtask

    task automatic exp_tile(input logic [7:0] idx, input logic [1:0] pal,
                            input logic [1:0] nt, input logic [4:0] x);
        tile_q.push_back('{index: idx, pal: pal, nt: nt, x: x});
    endtask

    // Pulse start for one cycle; the first read request must follow at once.
    task automatic start_burst(input logic [1:0] nt, input logic [4:0] x,
                               input logic [4:0] y, input logic [5:0] cnt);
        bus.start    = 1'b1;
        bus.start_nt = nt;
        bus.start_x  = x;
        bus.start_y  = y;
        bus.count    = cnt;
        @(posedge clk); #2;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("req_after_start", bus.mem_req, 1);
    endtask

    // Wait for the burst to finish and the FIFO to drain, bounded.
    task automatic wait_done();
        int i;
        for (i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            if (!bus.busy && tile_q.size() == 0 && !bus.tile_valid) break;
        end
        if (i == 500) fail("burst_timeout");
    endtask

    // VRAM responder: random or fixed ack latency, address-stability and read-order checks.
    initial begin
        logic        armed;
        int          wait_left;
        logic [15:0] req_addr;
        armed         = 1'b0;
        wait_left     = 0;
        req_addr      = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst || !bus.mem_req) begin
                armed       = 1'b0;
                bus.mem_ack = 1'b0;
            end else begin
                if (!armed) begin
                    armed     = 1'b1;
                    req_addr  = bus.mem_addr;
                    wait_left = int'($urandom_range(max_delay, min_delay));
                end else begin
                    check("addr_stable", bus.mem_addr, req_addr);
                end
                if (wait_left == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = vram[bus.mem_addr[13:0]];
                    armed         = 1'b0;
                    if (addr_q.size() == 0) fail("mem_read_unexpected");
                    else check("mem_read_addr", bus.mem_addr, addr_q.pop_front());
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_left--;
                end
            end
        end
    end

    // Tile monitor: compare every popped tile against the scoreboard.
    initial begin
        exp_tile_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.tile_valid && bus.tile_ready) begin
                if (tile_q.size() == 0) fail("tile_unexpected");
                else begin
                    e = tile_q.pop_front();
                    check("tile_out", {bus.tile_index, bus.tile_pal, bus.tile_nt, bus.tile_x}, e);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        for (int i = 0; i < 6; i++) vram[14'h2000 + i] = 8'h10 + 8'(i);
        vram[14'h23C0] = 8'hE4;
        vram[14'h23C1] = 8'h1B;
        vram[14'h20BE] = 8'hA1;
        vram[14'h20BF] = 8'hA2;
        vram[14'h24A0] = 8'hA3;
        vram[14'h24A1] = 8'hA4;
        vram[14'h23CF] = 8'h1B;
        vram[14'h27C8] = 8'hE4;
        vram[14'h2040] = 8'h40;
        vram[14'h2041] = 8'h41;
        vram[14'h2042] = 8'h42;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.start_nt   = '0;
        bus.start_x    = '0;
        bus.start_y    = '0;
        bus.count      = '0;
        bus.tile_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_tile_valid", bus.tile_valid, 0);
        check("rst_tile_data", {bus.tile_index, bus.tile_pal, bus.tile_nt, bus.tile_x}, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Single burst, zero-wait memory: one attribute miss then three hits.
        for (int pass = 0; pass < 2; pass++) begin
            min_delay = 0;
            max_delay = (pass == 0) ? 0 : 5;
            exp_read(16'h2000); exp_read(16'h23C0); exp_read(16'h2001);
            exp_read(16'h2002); exp_read(16'h2003);
            exp_tile(8'h10, 2'd0, 2'd0, 5'd0);
            exp_tile(8'h11, 2'd0, 2'd0, 5'd1);
            exp_tile(8'h12, 2'd1, 2'd0, 5'd2);
            exp_tile(8'h13, 2'd1, 2'd0, 5'd3);
            start_burst(2'd0, 5'd0, 5'd0, 6'd4);
            wait_done();

            // Horizontal wrap into nametable 1; a start during the burst is ignored.
            exp_read(16'h20BE); exp_read(16'h23CF); exp_read(16'h20BF);
            exp_read(16'h24A0); exp_read(16'h27C8); exp_read(16'h24A1);
            exp_tile(8'hA1, 2'd2, 2'd0, 5'd30);
            exp_tile(8'hA2, 2'd2, 2'd0, 5'd31);
            exp_tile(8'hA3, 2'd0, 2'd1, 5'd0);
            exp_tile(8'hA4, 2'd0, 2'd1, 5'd1);
            start_burst(2'd0, 5'd30, 5'd5, 6'd4);
            bus.start    = 1'b1;
            bus.start_nt = 2'd3;
            bus.start_x  = 5'd9;
            bus.start_y  = 5'd9;
            bus.count    = 6'd5;
            @(posedge clk); #2;
            bus.start = 1'b0;
            wait_done();

            // Palette quadrants with y[1]=1.
            exp_read(16'h2040); exp_read(16'h23C0); exp_read(16'h2041); exp_read(16'h2042);
            exp_tile(8'h40, 2'd2, 2'd0, 5'd0);
            exp_tile(8'h41, 2'd2, 2'd0, 5'd1);
            exp_tile(8'h42, 2'd3, 2'd0, 5'd2);
            start_burst(2'd0, 5'd0, 5'd2, 6'd3);
            wait_done();
        end
        min_delay = 0;
        max_delay = 0;

        // count=0 start is ignored.
        bus.start = 1'b1;
        bus.count = 6'd0;
        @(posedge clk); #2;
        bus.start = 1'b0;
        check("cnt0_busy", bus.busy, 0);
        check("cnt0_mem_req", bus.mem_req, 0);

        // Backpressure: four tiles fill the FIFO, the fifth stalls in PUSH.
        bus.tile_ready = 1'b0;
        exp_read(16'h2000); exp_read(16'h23C0); exp_read(16'h2001); exp_read(16'h2002);
        exp_read(16'h2003); exp_read(16'h2004); exp_read(16'h23C1); exp_read(16'h2005);
        exp_tile(8'h10, 2'd0, 2'd0, 5'd0);
        exp_tile(8'h11, 2'd0, 2'd0, 5'd1);
        exp_tile(8'h12, 2'd1, 2'd0, 5'd2);
        exp_tile(8'h13, 2'd1, 2'd0, 5'd3);
        exp_tile(8'h14, 2'd3, 2'd0, 5'd4);
        exp_tile(8'h15, 2'd3, 2'd0, 5'd5);
        start_burst(2'd0, 5'd0, 5'd0, 6'd6);
        repeat (40) @(posedge clk);
        #2;
        check("bp_busy", bus.busy, 1);
        check("bp_mem_req", bus.mem_req, 0);
        check("bp_tile_valid", bus.tile_valid, 1);
        check("bp_head_index", bus.tile_index, 8'h10);
        check("bp_reads_left", addr_q.size(), 1);
        bus.tile_ready = 1'b1;
        wait_done();

        // Reset while the attribute read is outstanding.
        min_delay = 3;
        max_delay = 3;
        exp_read(16'h2000);
        start_burst(2'd0, 5'd0, 5'd0, 6'd2);
        begin
            int i;
            for (i = 0; i < 30; i++) begin
                if (bus.mem_req && bus.mem_addr == 16'h23C0) break;
                @(posedge clk); #2;
            end
            if (i == 30) fail("reach_at_rd_timeout");
        end
        rst = 1'b1;
        @(posedge clk); #2;
        check("midrst_mem_req", bus.mem_req, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_tile_valid", bus.tile_valid, 0);
        check("midrst_reads_left", addr_q.size(), 0);
        rst = 1'b0;
        min_delay = 0;
        max_delay = 0;
        @(posedge clk); #2;

        // Fresh start after reset re-reads the attribute byte.
        exp_read(16'h2000); exp_read(16'h23C0);
        exp_tile(8'h10, 2'd0, 2'd0, 5'd0);
        start_burst(2'd0, 5'd0, 5'd0, 6'd1);
        wait_done();

        repeat (5) @(posedge clk);
        #2;
        check("reads_all_seen", addr_q.size(), 0);
        check("tiles_all_seen", tile_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
